hit_capture_reg: RTL and testbench

- Parametrised, fully synchronous successor to the TDC front-end input register.
- Per channel, it synchronises each hit line and detects its rising edge. It drives a fixed-length capture pulse on Q, with a global test-pulse source selectable per mode.
- Adds per-channel enable mask, sticky pile-up flags and saturating per-channel hit counters, read out through a request/acknowledge port.
- Sits between the trigger input pins and the TDC channel logic; counters feed slow-control rate monitoring.

---
 rtl/hit_capture_reg.sv | 203 ++++++++++++++++++++
 tb/tb_hit_capture_reg.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hit_capture_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hit_capture_reg
// Purpose  : TDC front-end input register. Synchronises every hit line (or a
//            shared test pulse), detects rising edges, stretches each edge
//            into a HOLD_CYCLES-long capture pulse, flags pile-up and keeps a
//            saturating hit counter per channel, readable by req/ack.
// Ports    : clk, rst          - system clock, async active-high reset
//            D_i, testsignal_i - asynchronous hit / test-pulse inputs
//            enTS_i            - 0: hits from D_i, 1: hits from testsignal_i
//            ch_mask_i         - per-channel enable (1 = enabled)
//            Q_o, hit_any_o    - capture pulses and their OR
//            pileup_o          - sticky "edge while Q already high"
//            cnt_clear_i       - clears all counters and pile-up flags
//            rd_req_i/rd_addr_i -> rd_ack_o/rd_data_o/rd_err_o counter read
// Revision : 1.0 - initial release
// ============================================================================
module hit_capture_reg #(
  parameter int WIDTH       = 48,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 1,
  parameter int CNT_WIDTH   = 16,
  parameter int ADDR_W      = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     D_i,
  input  logic                 testsignal_i,
  input  logic                 enTS_i,
  input  logic [WIDTH-1:0]     ch_mask_i,
  output logic [WIDTH-1:0]     Q_o,
  output logic                 hit_any_o,
  output logic [WIDTH-1:0]     pileup_o,
  input  logic                 cnt_clear_i,
  input  logic                 rd_req_i,
  input  logic [ADDR_W-1:0]    rd_addr_i,
  output logic                 rd_ack_o,
  output logic [CNT_WIDTH-1:0] rd_data_o,
  output logic                 rd_err_o
);

  localparam int                    c_HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [c_HOLD_W-1:0]   c_HOLD_LOAD = c_HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [c_HOLD_W-1:0]   c_HOLD_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0]  c_CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0]  c_CNT_ONE   = 1;

  // --------------------------------------------------------------------------
  // Input synchronisers and mode tracking
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]       d_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] ts_sync_q;
  logic                   mode_q;
  logic                   mode_dly_q;
  logic [WIDTH-1:0]       prev_q;

  logic [WIDTH-1:0]       w_src;
  logic                   w_mode_stable;
  logic [WIDTH-1:0]       w_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        d_sync_q[s] <= '0;
      end
      ts_sync_q  <= '0;
      mode_q     <= 1'b0;
      mode_dly_q <= 1'b0;
      prev_q     <= '0;
    end else begin
      d_sync_q[0] <= D_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        d_sync_q[s] <= d_sync_q[s-1];
      end
      ts_sync_q  <= {ts_sync_q[SYNC_STAGES-2:0], testsignal_i};
      mode_q     <= enTS_i;
      mode_dly_q <= mode_q;
      // Tracks the source regardless of mask so that unmasking a channel that
      // is already high does not look like a fresh edge.
      prev_q     <= w_src;
    end
  end

  assign w_src = mode_q ? {WIDTH{ts_sync_q[SYNC_STAGES-1]}} : d_sync_q[SYNC_STAGES-1];

  // prev_q still holds the old source for one cycle after a mode switch, so
  // edges are blanked in that cycle to avoid a spurious hit.
  assign w_mode_stable = (mode_q == mode_dly_q);
  assign w_edge        = w_src & ~prev_q & ch_mask_i & {WIDTH{w_mode_stable}};

  // --------------------------------------------------------------------------
  // Capture pulse, pile-up flag and hit counter per channel
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]     q_q,    q_d;
  logic [c_HOLD_W-1:0]  hold_q [WIDTH];
  logic [c_HOLD_W-1:0]  hold_d [WIDTH];
  logic [WIDTH-1:0]     pile_q, pile_d;
  logic [CNT_WIDTH-1:0] cnt_q  [WIDTH];
  logic [CNT_WIDTH-1:0] cnt_d  [WIDTH];

  always_comb begin
    q_d    = q_q;
    hold_d = hold_q;
    pile_d = pile_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (q_q[i]) begin
        // An edge during an active pulse never retriggers or extends it.
        if (hold_q[i] == '0) begin
          q_d[i] = 1'b0;
        end else begin
          hold_d[i] = hold_q[i] - c_HOLD_ONE;
        end
        if (w_edge[i]) begin
          pile_d[i] = 1'b1;
        end
      end else if (w_edge[i]) begin
        q_d[i]    = 1'b1;
        hold_d[i] = c_HOLD_LOAD;
      end
      if (w_edge[i] && (cnt_q[i] != c_CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + c_CNT_ONE;
      end
    end
    // Clear takes priority over a same-cycle edge; Q is deliberately untouched.
    if (cnt_clear_i) begin
      pile_d = '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_d[i] = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      pile_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        hold_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      q_q    <= q_d;
      pile_q <= pile_d;
      hold_q <= hold_d;
      cnt_q  <= cnt_d;
    end
  end

  assign Q_o       = q_q;
  assign hit_any_o = |q_q;
  assign pileup_o  = pile_q;

  // --------------------------------------------------------------------------
  // Counter read port: returns the count registered before the request edge
  // --------------------------------------------------------------------------
  logic [CNT_WIDTH-1:0] w_rd_val;
  logic                 w_rd_hit;
  logic                 rd_ack_q,  rd_ack_d;
  logic                 rd_err_q,  rd_err_d;
  logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;

  always_comb begin
    w_rd_val = '0;
    w_rd_hit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (rd_addr_i == ADDR_W'(i)) begin
        w_rd_val = cnt_q[i];
        w_rd_hit = 1'b1;
      end
    end
  end

  always_comb begin
    rd_ack_d  = 1'b0;
    rd_err_d  = 1'b0;
    rd_data_d = rd_data_q;
    if (rd_req_i) begin
      rd_ack_d  = 1'b1;
      rd_err_d  = ~w_rd_hit;
      rd_data_d = w_rd_hit ? w_rd_val : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ack_q  <= 1'b0;
      rd_err_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= rd_ack_d;
      rd_err_q  <= rd_err_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_ack_o  = rd_ack_q;
  assign rd_err_o  = rd_err_q;
  assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_hit_capture_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hit_capture_reg
// Purpose  : Scoreboard bench for hit_capture_reg (HOLD_CYCLES=4, CNT_WIDTH=4).
//            Stimulus pushes expected capture pulses and read responses into
//            queues; a negedge monitor pops and compares them as the DUT
//            presents Q pulses and rd_ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hit_capture_reg;

  localparam int WIDTH = 48;
  localparam int SYNC  = 2;
  localparam int HOLD  = 4;
  localparam int CW    = 4;
  localparam int AW    = 6;
  // Input set at the negedge numbered c shows up on Q at negedge c+LAT.
  localparam int LAT   = SYNC + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] D = '0;
  logic             testsignal = 1'b0;
  logic             enTS = 1'b0;
  logic [WIDTH-1:0] ch_mask = '1;
  logic             cnt_clear = 1'b0;
  logic             rd_req = 1'b0;
  logic [AW-1:0]    rd_addr = '0;
  logic [WIDTH-1:0] Q;
  logic             hit_any;
  logic [WIDTH-1:0] pileup;
  logic             rd_ack;
  logic [CW-1:0]    rd_data;
  logic             rd_err;

  hit_capture_reg #(
    .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD),
    .CNT_WIDTH(CW), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .D_i(D), .testsignal_i(testsignal), .enTS_i(enTS),
    .ch_mask_i(ch_mask), .Q_o(Q), .hit_any_o(hit_any), .pileup_o(pileup),
    .cnt_clear_i(cnt_clear), .rd_req_i(rd_req), .rd_addr_i(rd_addr),
    .rd_ack_o(rd_ack), .rd_data_o(rd_data), .rd_err_o(rd_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [WIDTH-1:0] q; int start; } qexp_t;
  typedef struct { logic [CW-1:0] data; logic err; } rexp_t;
  qexp_t q_sb[$];
  rexp_t r_sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [WIDTH-1:0] bitv(input int i);
    logic [WIDTH-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic expect_q(input logic [WIDTH-1:0] v, input int st);
    qexp_t e;
    e.q = v;
    e.start = st;
    q_sb.push_back(e);
  endtask

  task automatic rd(input int a, input logic [CW-1:0] d, input logic e);
    rexp_t x;
    @(negedge clk);
    rd_req  = 1'b1;
    rd_addr = AW'(a);
    x.data  = d;
    x.err   = e;
    r_sb.push_back(x);
    @(negedge clk);
    rd_req  = 1'b0;
  endtask

  task automatic push_rd(input int a, input logic [CW-1:0] d, input logic e);
    rexp_t x;
    rd_req  = 1'b1;
    rd_addr = AW'(a);
    x.data  = d;
    x.err   = e;
    r_sb.push_back(x);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: pops expected Q pulses and read responses as they appear
  // --------------------------------------------------------------------------
  bit               in_pulse = 1'b0;
  int               len = 0;
  logic [WIDTH-1:0] cur = '0;
  qexp_t            mq;
  rexp_t            mr;

  always @(negedge clk) begin
    if (rst) begin
      in_pulse = 1'b0;
    end else begin
      if (Q != '0) begin
        if (!in_pulse) begin
          if (q_sb.size() == 0) begin
            chk("q_unexpected", 64'(Q), 64'd0);
            cur = '0;
          end else begin
            mq = q_sb.pop_front();
            chk("q_value", 64'(Q), 64'(mq.q));
            chk("q_start", 64'(cyc), 64'(mq.start));
            cur = mq.q;
          end
          in_pulse = 1'b1;
          len = 1;
        end else begin
          len++;
          chk("q_hold", 64'(Q), 64'(cur));
        end
        chk("hit_any_hi", 64'(hit_any), 64'd1);
      end else begin
        if (in_pulse) begin
          chk("q_len", 64'(len), 64'(HOLD));
          in_pulse = 1'b0;
        end
        chk("hit_any_lo", 64'(hit_any), 64'd0);
      end
      if (rd_ack) begin
        if (r_sb.size() == 0) begin
          chk("rd_ack_unexpected", 64'd1, 64'd0);
        end else begin
          mr = r_sb.pop_front();
          chk("rd_data", 64'(rd_data), 64'(mr.data));
          chk("rd_err", 64'(rd_err), 64'(mr.err));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  initial begin
    int c;
    tick(3);
    chk("rst_q", 64'(Q), 64'd0);
    chk("rst_hit_any", 64'(hit_any), 64'd0);
    chk("rst_pileup", 64'(pileup), 64'd0);
    chk("rst_rd_ack", 64'(rd_ack), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_rd_err", 64'(rd_err), 64'd0);
    rst = 1'b0;
    tick(3);

    // Single hit on channel 5, D held high for 10 cycles.
    c = cyc;
    D[5] = 1'b1;
    expect_q(bitv(5), c + LAT);
    tick(10);
    D[5] = 1'b0;
    tick(4);
    chk("pileup_single", 64'(pileup), 64'd0);

    // Second edge on channel 0 inside the hold window -> pile-up.
    c = cyc;
    D[0] = 1'b1;
    expect_q(bitv(0), c + LAT);
    tick(1); D[0] = 1'b0;
    tick(1); D[0] = 1'b1;
    tick(1); D[0] = 1'b0;
    tick(8);
    chk("pileup_ch0", 64'(pileup), 64'(bitv(0)));
    rd(0, 4'd2, 1'b0);
    rd(5, 4'd1, 1'b0);

    // 20 edges every 2 cycles on channel 7: a new pulse only every third edge.
    c = cyc;
    for (int k = 0; k < 20; k++) begin
      D[7] = 1'b1;
      if (k % 3 == 0) expect_q(bitv(7), c + 2 * k + LAT);
      tick(1);
      D[7] = 1'b0;
      tick(1);
    end
    tick(8);
    chk("pileup_ch0_ch7", 64'(pileup), 64'(bitv(0) | bitv(7)));

    // Back-to-back reads: three requests, three acks.
    push_rd(5, 4'd1, 1'b0);  tick(1);
    push_rd(0, 4'd2, 1'b0);  tick(1);
    push_rd(7, 4'd15, 1'b0); tick(1);
    rd_req = 1'b0;
    tick(2);
    chk("rd_data_hold", 64'(rd_data), 64'd15);
    chk("rd_ack_idle", 64'(rd_ack), 64'd0);
    chk("rd_err_idle", 64'(rd_err), 64'd0);
    rd(47, 4'd0, 1'b0);
    rd(48, 4'd0, 1'b1);
    rd(50, 4'd0, 1'b1);
    rd(63, 4'd0, 1'b1);

    // Clear coinciding with an edge on channel 9: clear wins, Q unaffected.
    c = cyc;
    D[9] = 1'b1;
    expect_q(bitv(9), c + LAT);
    tick(2);
    cnt_clear = 1'b1;
    tick(1);
    cnt_clear = 1'b0;
    tick(8);
    D[9] = 1'b0;
    tick(2);
    chk("pileup_cleared", 64'(pileup), 64'd0);
    rd(9, 4'd0, 1'b0);
    rd(7, 4'd0, 1'b0);
    rd(0, 4'd0, 1'b0);

    // Test mode with only channels 3:0 enabled.
    ch_mask = 48'h0000_0000_000F;
    enTS = 1'b1;
    tick(4);
    c = cyc;
    testsignal = 1'b1;
    expect_q(48'h0000_0000_000F, c + LAT);
    tick(1);
    testsignal = 1'b0;
    tick(8);
    // D is ignored in test mode; leaving it while D[0] is high must not hit.
    D[0] = 1'b1;
    tick(4);
    enTS = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk("q_mode_switch", 64'(Q), 64'd0);
    end
    D[0] = 1'b0;
    tick(2);
    ch_mask = '1;
    tick(2);
    rd(3, 4'd1, 1'b0);
    rd(4, 4'd0, 1'b0);
    rd(0, 4'd1, 1'b0);

    // Reset in the middle of a pulse, with pile-up set and a read in flight.
    c = cyc;
    D[2] = 1'b1;
    expect_q(bitv(2), c + LAT);
    tick(1); D[2] = 1'b0;
    tick(1); D[2] = 1'b1;
    tick(1); D[2] = 1'b0;
    tick(2);
    chk("pileup_ch2", 64'(pileup), 64'(bitv(2)));
    rd_req  = 1'b1;
    rd_addr = AW'(3);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_q", 64'(Q), 64'd0);
    chk("arst_hit_any", 64'(hit_any), 64'd0);
    chk("arst_rd_ack", 64'(rd_ack), 64'd0);
    chk("arst_rd_data", 64'(rd_data), 64'd0);
    chk("arst_rd_err", 64'(rd_err), 64'd0);
    chk("arst_pileup", 64'(pileup), 64'd0);
    @(negedge clk);
    rd_req = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
    rd(2, 4'd0, 1'b0);
    rd(3, 4'd0, 1'b0);

    // First edge after reset release.
    c = cyc;
    D[2] = 1'b1;
    expect_q(bitv(2), c + LAT);
    tick(8);
    D[2] = 1'b0;
    tick(2);
    rd(2, 4'd1, 1'b0);

    tick(5);
    chk("q_sb_drained", 64'(q_sb.size()), 64'd0);
    chk("r_sb_drained", 64'(r_sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
